// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, RGB332 field layout and colour helpers.
// Used by the scan-out stage and by the sprite/maze colour tables.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W = 10;

    // RGB332 layout: {R[2:0], G[2:0], B[1:0]}
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam logic [7:0] BLK = 8'h00;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } raster_t;

    localparam raster_t RASTER_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

    // MSB replication keeps full-scale inputs mapping to full-scale outputs.
    function automatic rgb444_t expand_rgb332(input logic [7:0] p);
        rgb444_t c;
        c.r = {p[R_MSB:R_LSB], p[R_MSB]};
        c.g = {p[G_MSB:G_LSB], p[G_MSB]};
        c.b = {p[B_MSB:B_LSB], p[B_MSB:B_LSB]};
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset to a chosen idle value.
module vga_delay_line #(
    parameter int             W       = 3,
    parameter int             DEPTH   = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH-1:0][W-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= {DEPTH{RST_VAL}};
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: raster counters, sync/blank generation delayed to meet the
// returning pixel stream, and RGB332 -> RGB444 pin register.
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       pixel_in,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             frame_tick,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    raster_t raw;
    raster_t dly;
    rgb444_t pix_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hc         <= '0;
            vc         <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (hc == H_LAST) && (vc == V_LAST);
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    always_comb begin
        raw        = RASTER_IDLE;
        raw.hs     = !((hc >= HS_FIRST) && (hc <= HS_LAST));
        raw.vs     = !((vc >= VS_FIRST) && (vc <= VS_LAST));
        raw.active = (hc < H_ACT_END) && (vc < V_ACT_END);
    end

    // Matches the latency of the frame-buffer read so sync and colour stay coincident.
    vga_delay_line #(
        .W       ($bits(raster_t)),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (RASTER_IDLE)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d   (raw),
        .q   (dly)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            pix_q  <= expand_rgb332(BLK);
        end else begin
            vga_hs <= dly.hs;
            vga_vs <= dly.vs;
            pix_q  <= dly.active ? expand_rgb332(pixel_in) : expand_rgb332(BLK);
        end
    end

    assign vga_r = pix_q.r;
    assign vga_g = pix_q.g;
    assign vga_b = pix_q.b;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: full 640x480 instance for line-level behaviour,
// shrunken-timing instance for frame, vsync, blanking and mid-frame reset.
module tb_vga_scan_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- full-timing instance ----------------
    logic       rst_f = 1'b1;
    logic [7:0] pix_f = 8'h00;
    logic [9:0] hc_f, vc_f;
    logic       ft_f, hs_f, vs_f;
    logic [3:0] r_f, g_f, b_f;

    vga_scan_out u_full (
        .clk (clk), .rst (rst_f), .pixel_in (pix_f),
        .hc (hc_f), .vc (vc_f), .frame_tick (ft_f),
        .vga_hs (hs_f), .vga_vs (vs_f),
        .vga_r (r_f), .vga_g (g_f), .vga_b (b_f)
    );

    // ---------------- small-timing instance ----------------
    // H: 20+4+6+5 = 35, V: 6+2+2+3 = 13, frame = 455 cycles
    localparam int SH = 35;
    localparam int SV = 13;
    localparam int SF = SH * SV;

    logic       rst_s = 1'b1;
    logic [7:0] pix_s = 8'hFF;
    logic [9:0] hc_s, vc_s;
    logic       ft_s, hs_s, vs_s;
    logic [3:0] r_s, g_s, b_s;

    vga_scan_out #(
        .H_ACTIVE (20), .H_FP (4), .H_SYNC (6), .H_BP (5),
        .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .PIPE_DELAY (2)
    ) u_small (
        .clk (clk), .rst (rst_s), .pixel_in (pix_s),
        .hc (hc_s), .vc (vc_s), .frame_tick (ft_s),
        .vga_hs (hs_s), .vga_vs (vs_s),
        .vga_r (r_s), .vga_g (g_s), .vga_b (b_s)
    );

    typedef struct {
        logic [7:0]  pix;
        logic [11:0] rgb;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        int falls[$];
        int rises[$];
        int vs_low_f, act_err, blk_err;
        int hs_err, vs_err, ft_err, ticks, u, h, v;
        int vfalls[$];
        int vrises[$];
        logic prev;
        logic [11:0] exp_col;
        logic exp_hs, exp_vs, exp_ft;

        vecs[0] = '{8'hE0, 12'hF00};
        vecs[1] = '{8'h1F, 12'h0FF};
        vecs[2] = '{8'hFF, 12'hFFF};
        vecs[3] = '{8'h00, 12'h000};
        vecs[4] = '{8'hA5, 12'hB25};
        vecs[5] = '{8'h4A, 12'h44A};
        vecs[6] = '{8'h24, 12'h220};
        vecs[7] = '{8'h92, 12'h99A};

        // ---- full instance: reset ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_hc", 32'(hc_f), 32'd0);
            chk("rst_vc", 32'(vc_f), 32'd0);
            chk("rst_sync", 32'({hs_f, vs_f, ft_f}), 32'b110);
            chk("rst_col", 32'({r_f, g_f, b_f}), 32'd0);
        end
        rst_f = 1'b0;
        chk("rel_hc0", 32'(hc_f), 32'd0);
        chk("rel_ft0", 32'(ft_f), 32'd0);

        prev = 1'b1;
        vs_low_f = 0; act_err = 0; blk_err = 0;
        for (int t = 1; t <= 1700; t++) begin
            @(negedge clk);
            if (t == 1) chk("hc_second", 32'(hc_f), 32'd1);
            if (t <= 2) chk("pre_active_black", 32'({r_f, g_f, b_f}), 32'd0);
            if (t == 3) chk("align_first_px", 32'({r_f, g_f, b_f}), 32'hF00);
            if (t == 4) chk("align_next_px", 32'({r_f, g_f, b_f}), 32'h000);
            if (t >= 7 && t < 7 + 2 * NV && ((t - 7) % 2) == 0)
                chk($sformatf("vec%0d", (t - 7) / 2), 32'({r_f, g_f, b_f}),
                    32'(vecs[(t - 7) / 2].rgb));
            if (t == 799) chk("h_last", 32'({vc_f, hc_f}), 32'({10'd0, 10'd799}));
            if (t == 800) chk("h_wrap", 32'({vc_f, hc_f}), 32'({10'd1, 10'd0}));
            if (prev && !hs_f) falls.push_back(t);
            if (!prev && hs_f) rises.push_back(t);
            prev = hs_f;
            if (!vs_f) vs_low_f++;
            if (t >= 601) begin
                h = (t - 3) % 800;
                if (h < 640) begin
                    if ({r_f, g_f, b_f} !== 12'hFFF) act_err++;
                end else begin
                    if ({r_f, g_f, b_f} !== 12'h000) blk_err++;
                end
            end
            // stimulus for the edge ending this cycle
            if (t == 2) pix_f = 8'hE0;
            else if (t >= 6 && t < 6 + 2 * NV && ((t - 6) % 2) == 0) pix_f = vecs[(t - 6) / 2].pix;
            else if (t >= 600) pix_f = 8'hFF;
            else pix_f = 8'h00;
        end
        chk("hs_fall_count", 32'(falls.size()), 32'd2);
        if (falls.size() == 2 && rises.size() >= 1) begin
            chk("hs_fall", 32'(falls[0]), 32'd659);
            chk("hs_width", 32'(rises[0] - falls[0]), 32'd96);
            chk("hs_period", 32'(falls[1] - falls[0]), 32'd800);
        end
        chk("vs_high_early", 32'(vs_low_f), 32'd0);
        chk("full_active_ff", 32'(act_err), 32'd0);
        chk("full_hblank", 32'(blk_err), 32'd0);

        // ---- small instance: frames, vsync, blanking ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s_rst_state", 32'({hc_s, vc_s, ft_s, hs_s, vs_s}), 32'({20'd0, 3'b011}));
        end
        rst_s = 1'b0;
        hs_err = 0; vs_err = 0; ft_err = 0; act_err = 0; blk_err = 0; ticks = 0;
        prev = 1'b1;
        for (int t = 0; t <= 1025; t++) begin
            if (t > 0) @(negedge clk);
            u = t - 3;
            if (u < 0) begin
                exp_hs = 1'b1; exp_vs = 1'b1; exp_col = 12'h000;
            end else begin
                h = u % SH;
                v = (u / SH) % SV;
                exp_hs  = !(h >= 24 && h <= 29);
                exp_vs  = !(v >= 8 && v <= 9);
                exp_col = (h < 20 && v < 6) ? 12'hFFF : 12'h000;
            end
            exp_ft = (t > 0) && (t % SF == 0);
            if (hs_s !== exp_hs) hs_err++;
            if (vs_s !== exp_vs) vs_err++;
            if (ft_s !== exp_ft) ft_err++;
            if (ft_s) ticks++;
            if (exp_col == 12'hFFF) begin
                if ({r_s, g_s, b_s} !== exp_col) act_err++;
            end else begin
                if ({r_s, g_s, b_s} !== exp_col) blk_err++;
            end
            if (prev && !vs_s) vfalls.push_back(t);
            if (!prev && vs_s) vrises.push_back(t);
            prev = vs_s;
            if (t == SF) chk("s_wrap_both", 32'({hc_s, vc_s}), 32'd0);
        end
        chk("s_hs_pattern", 32'(hs_err), 32'd0);
        chk("s_vs_pattern", 32'(vs_err), 32'd0);
        chk("s_tick_pattern", 32'(ft_err), 32'd0);
        chk("s_tick_count", 32'(ticks), 32'd2);
        chk("s_active_ff", 32'(act_err), 32'd0);
        chk("s_blank", 32'(blk_err), 32'd0);
        chk("s_vs_falls", 32'(vfalls.size()), 32'd2);
        if (vfalls.size() == 2 && vrises.size() >= 1) begin
            chk("s_vs_fall", 32'(vfalls[0]), 32'd283);
            chk("s_vs_width", 32'(vrises[0] - vfalls[0]), 32'd70);
            chk("s_vs_period", 32'(vfalls[1] - vfalls[0]), 32'(SF));
        end

        // ---- small instance: one-cycle reset mid-frame at (10,3) ----
        chk("s_mid_pos", 32'({vc_s, hc_s}), 32'({10'd3, 10'd10}));
        rst_s = 1'b1;
        @(negedge clk);
        chk("mid_cnt_zero", 32'({hc_s, vc_s, ft_s}), 32'd0);
        chk("mid_out_idle", 32'({hs_s, vs_s, r_s, g_s, b_s}), 32'({2'b11, 12'h000}));
        rst_s = 1'b0;
        ft_err = 0; ticks = 0; blk_err = 0;
        for (int j = 1; j <= 460; j++) begin
            @(negedge clk);
            if (j == 1) chk("mid_hc1", 32'(hc_s), 32'd1);
            if (j <= 2 && {hs_s, vs_s, r_s, g_s, b_s} !== {2'b11, 12'h000}) blk_err++;
            if (j == 3) chk("mid_first_px", 32'({hs_s, vs_s, r_s, g_s, b_s}), 32'({2'b11, 12'hFFF}));
            if (ft_s) ticks++;
            if (ft_s !== (j == SF)) ft_err++;
        end
        chk("mid_flush", 32'(blk_err), 32'd0);
        chk("mid_tick_pos", 32'(ft_err), 32'd0);
        chk("mid_tick_count", 32'(ticks), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
